// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a separate load port, a READ_LAT-deep
// response pipeline and fault reporting. The memory self-fills with FILL_WORD after reset.
module instr_fetch_mem #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter int                READ_LAT  = 1,
    parameter int                BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = 32'h0BADCAFE,
    parameter logic [DATA_W-1:0] OOB_WORD  = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        rsp_fault_o,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_err_o,
    output logic              init_busy_o
);

    localparam int OFFS = (BYTE_ADDR != 0) ? $clog2(DATA_W / 8) : 0;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFFS) - 64'd1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [READ_LAT-1:0] vld_q;
    logic [1:0]          flt_q [READ_LAT];
    logic [DATA_W-1:0]   dat_q [READ_LAT];
    logic                load_err_q;

    logic              stall;
    logic              accept;
    logic              load_ok;
    logic [1:0]        fetch_flt;
    logic [1:0]        load_flt;
    logic [DATA_W-1:0] fetch_word;

    // The full word index is compared against DEPTH so high address bits can never alias.
    function automatic logic [1:0] decodeFault(input logic [ADDR_W-1:0] addr);
        logic [1:0] flt;
        flt = 2'b00;
        if ((addr & LOW_MASK) != '0) begin
            flt = 2'b10;
        end else if (64'(addr >> OFFS) >= 64'(DEPTH)) begin
            flt = 2'b01;
        end
        return flt;
    endfunction

    function automatic logic [AW-1:0] wordIndex(input logic [ADDR_W-1:0] addr);
        return AW'(addr >> OFFS);
    endfunction

    assign fetch_flt  = decodeFault(fetch_addr_i);
    assign load_flt   = decodeFault(load_addr_i);
    assign fetch_word = (fetch_flt == 2'b00) ? mem_q[wordIndex(fetch_addr_i)] : OOB_WORD;

    assign stall         = vld_q[READ_LAT-1] && !rsp_ready_i;
    assign fetch_ready_o = (state_q == S_RUN) && !stall;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign load_ok       = load_en_i && (state_q == S_RUN) && (load_flt == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_err_q <= load_en_i && !load_ok;
        end
    end

    // Single write port: the init sweep owns it during INIT, loads own it in RUN.
    // Fetch reads above use the pre-edge contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[cnt_q] <= FILL_WORD;
        end else if (load_ok) begin
            mem_q[wordIndex(load_addr_i)] <= load_data_i;
        end
    end

    // Whole pipeline freezes on stall; payloads only move behind a valid so outputs hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                flt_q[i] <= 2'b00;
                dat_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
                flt_q[0] <= fetch_flt;
                dat_q[0] <= fetch_word;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    flt_q[i] <= flt_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rsp_valid_o = vld_q[READ_LAT-1];
    assign rsp_data_o  = dat_q[READ_LAT-1];
    assign rsp_fault_o = flt_q[READ_LAT-1];
    assign load_err_o  = load_err_q;
    assign init_busy_o = (state_q == S_INIT);

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: a queue/array reference model checked every cycle, plus
// directed fetch/load scenarios with literal expected values.
module tb_instr_fetch_mem;

    localparam int          DEPTH    = 1024;
    localparam int          READ_LAT = 2;
    localparam logic [31:0] FILL     = 32'h0BADCAFE;
    localparam logic [31:0] OOB      = 32'hDEADBEEF;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr  = '0;
    logic        rsp_ready   = 1'b1;
    logic        load_en     = 1'b0;
    logic [31:0] load_addr   = '0;
    logic [31:0] load_data   = '0;
    logic        fetch_ready, rsp_valid, load_err, init_busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;
    logic [31:0] gotQ[$];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        int          w;
    } rsp_t;

    rsp_t      modelQ[$];
    bit [31:0] modelMem[DEPTH];
    int        initLeft     = DEPTH;
    bit        modelLoadErr = 1'b0;

    instr_fetch_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .BYTE_ADDR(1),
        .FILL_WORD(FILL), .OOB_WORD(OOB)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready), .fetch_addr_i(fetch_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_fault_o(rsp_fault), .load_en_i(load_en), .load_addr_i(load_addr),
        .load_data_i(load_data), .load_err_o(load_err), .init_busy_o(init_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] faultOf(input logic [31:0] a);
        if (a % 4 != 0) return 2'b10;
        if (a / 4 >= 32'(DEPTH)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit modelVisible();
        return modelQ.size() > 0 && modelQ[0].w == 0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Reference model: requests wait READ_LAT unstalled cycles, then leave in order.
    initial forever begin
        bit   vis, stallM, acc, lerr;
        rsp_t e;
        @(posedge clk or posedge reset);
        if (reset) begin
            modelQ.delete();
            initLeft     = DEPTH;
            modelLoadErr = 1'b0;
        end else begin
            vis    = modelVisible();
            stallM = vis && !rsp_ready;
            acc    = fetch_valid && initLeft == 0 && !stallM;
            lerr   = load_en && (initLeft > 0 || faultOf(load_addr) != 2'b00);
            if (!stallM) begin
                if (vis) void'(modelQ.pop_front());
                foreach (modelQ[i]) if (modelQ[i].w > 0) modelQ[i].w--;
            end
            if (acc) begin
                e.fault = faultOf(fetch_addr);
                e.data  = (e.fault == 2'b00) ? modelMem[fetch_addr / 4] : OOB;
                e.w     = READ_LAT - 1;
                modelQ.push_back(e);
            end
            if (load_en && !lerr) modelMem[load_addr / 4] = load_data;
            if (initLeft > 0) begin
                modelMem[DEPTH - initLeft] = FILL;
                initLeft--;
            end
            modelLoadErr = lerr;
        end
    end

    initial forever begin
        bit vis;
        @(negedge clk);
        vis = modelVisible();
        checkOutput("cycInitBusy", init_busy, initLeft > 0);
        checkOutput("cycFetchReady", fetch_ready, initLeft == 0 && !(vis && !rsp_ready));
        checkOutput("cycRspValid", rsp_valid, vis);
        checkOutput("cycLoadErr", load_err, modelLoadErr);
        if (vis) begin
            checkOutput("cycRspData", rsp_data, modelQ[0].data);
            checkOutput("cycRspFault", rsp_fault, modelQ[0].fault);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && rsp_valid && rsp_ready) gotQ.push_back(rsp_data);
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, output int accCycle);
        accCycle    = -1;
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fetch_ready) accCycle = cycle;
            stepCycle();
            if (accCycle >= 0) break;
        end
        fetch_valid = 1'b0;
        if (accCycle < 0) checkOutput("fetchAcceptTimeout", 0, 1);
    endtask

    task automatic waitResponse(output logic [31:0] d, output logic [1:0] f, output int rc);
        rc = -1;
        d  = '0;
        f  = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                d  = rsp_data;
                f  = rsp_fault;
                rc = cycle;
            end
            stepCycle();
            if (rc >= 0) break;
        end
        if (rc < 0) checkOutput("rspTimeout", 0, 1);
    endtask

    task automatic fetchAndCheck(input string name, input logic [31:0] addr,
                                 input logic [31:0] expData, input logic [1:0] expFault);
        int          acc, rc;
        logic [31:0] d;
        logic [1:0]  f;
        applyStimulus(addr, acc);
        waitResponse(d, f, rc);
        checkOutput({name, "Data"}, d, expData);
        checkOutput({name, "Fault"}, f, expFault);
        checkOutput({name, "Lat"}, 64'(rc - acc), 64'(READ_LAT));
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        stepCycle();
        load_en = 1'b0;
    endtask

    task automatic countInit(input bit withLoad, output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
            if (withLoad && k == 1) checkOutput("initLoadErr", load_err, 1);
            stepCycle();
            load_en = 1'b0;
        end
        stepCycle();
    endtask

    initial begin
        int   n, a0, a1, a2, gotBefore;
        bit   sawValid;
        logic [31:0] r [3];

        $display("[TB] start");
        repeat (2) @(negedge clk);
        checkOutput("rstInitBusy", init_busy, 1);
        checkOutput("rstFetchReady", fetch_ready, 0);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstRspData", rsp_data, 0);
        checkOutput("rstRspFault", rsp_fault, 0);
        checkOutput("rstLoadErr", load_err, 0);
        stepCycle();
        reset = 1'b0;

        countInit(1'b0, n);
        checkOutput("initCycles", n, DEPTH);
        fetchAndCheck("t1Word5", 32'h14, FILL, 2'b00);

        doLoad(32'h10, 32'h13);
        fetchAndCheck("t2Load", 32'h10, 32'h13, 2'b00);

        fetchAndCheck("t3Misalign", 32'h1002, OOB, 2'b10);
        fetchAndCheck("t3Oob", 32'h1000, OOB, 2'b01);
        fetchAndCheck("t3BothFaults", 32'h1003, OOB, 2'b10);
        fetchAndCheck("t3LastWord", 32'hFFC, FILL, 2'b00);
        fetchAndCheck("t3HighAlias", 32'h8000_0000, OOB, 2'b01);

        doLoad(32'h0, 32'h100);
        doLoad(32'h4, 32'h104);
        doLoad(32'h8, 32'h108);
        gotQ.delete();
        rsp_ready = 1'b0;
        fork
            begin
                applyStimulus(32'h0, a0);
                applyStimulus(32'h4, a1);
                applyStimulus(32'h8, a2);
            end
            begin
                sawValid = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        sawValid = 1'b1;
                        break;
                    end
                end
                checkOutput("t4StallSeen", sawValid, 1);
                checkOutput("t4StallReady", fetch_ready, 0);
                repeat (3) stepCycle();
                rsp_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && gotQ.size() < 3; k++) stepCycle();
        repeat (4) stepCycle();
        checkOutput("t4RspCount", gotQ.size(), 3);
        for (int i = 0; i < 3; i++) r[i] = (gotQ.size() > i) ? gotQ[i] : 32'h0;
        checkOutput("t4Rsp0", r[0], 32'h100);
        checkOutput("t4Rsp1", r[1], 32'h104);
        checkOutput("t4Rsp2", r[2], 32'h108);

        doLoad(32'h20, 32'h1111);
        doLoad(32'h1000, 32'h0BAD);
        @(negedge clk);
        checkOutput("t5OobLoadErr", load_err, 1);
        stepCycle();
        @(negedge clk);
        checkOutput("t5LoadErrPulse", load_err, 0);
        stepCycle();
        fetchAndCheck("t5NoAlias", 32'h0, 32'h100, 2'b00);
        load_en   = 1'b1;
        load_addr = 32'h20;
        load_data = 32'h2222;
        fetchAndCheck("t5ReadFirst", 32'h20, 32'h1111, 2'b00);
        fetchAndCheck("t5AfterWrite", 32'h20, 32'h2222, 2'b00);

        rsp_ready = 1'b0;
        applyStimulus(32'h0, a0);
        applyStimulus(32'h4, a1);
        gotBefore = gotQ.size();
        reset = 1'b1;
        #1;
        checkOutput("t6RspValidDrop", rsp_valid, 0);
        checkOutput("t6InitBusy", init_busy, 1);
        checkOutput("t6FetchReady", fetch_ready, 0);
        stepCycle();
        stepCycle();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        load_en   = 1'b1;
        load_addr = 32'h30;
        load_data = 32'h77;
        countInit(1'b1, n);
        checkOutput("t6InitCycles", n, DEPTH);
        checkOutput("t6NoResponses", gotQ.size(), gotBefore);
        fetchAndCheck("t6InitLoadIgnored", 32'h30, FILL, 2'b00);
        fetchAndCheck("t6Refilled", 32'h0, FILL, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
